sha256_nonce_sequencer: RTL

Sequencing controller for the `simplified_sha256` core in the bitcoin hashing path. It sweeps a range of nonces over one 20-word message. For each nonce it:
- writes the nonce into message word 19 of shared memory;
- launches the core;
- waits for the core to finish;
- advances the output pointer by 8 words.

It owns the single memory port and muxes it between its own nonce writes and the core.

---
 rtl/sha256_nonce_sequencer_if.sv | 53 +++++
 rtl/sha256_nonce_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_sequencer_if.sv
// Bundle of the host, core and memory-port signals around the nonce sequencer.
// The slave view belongs to the sequencer; the master view belongs to
// whatever surrounds it (host, core, memory).
interface sha256_nonce_sequencer_if;
  // host side
  logic        start;
  logic        abort;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic [31:0] nonce_first;
  logic [15:0] nonce_count;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] nonces_done;

  // hash core side
  logic        core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_done;
  logic        core_mem_we;
  logic [15:0] core_mem_addr;
  logic [31:0] core_mem_write_data;
  logic [31:0] core_mem_read_data;

  // shared memory port
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  start, abort, message_addr, output_addr, nonce_first, nonce_count,
    output busy, done, aborted, nonces_done,
    output core_start, core_message_addr, core_output_addr,
    input  core_done, core_mem_we, core_mem_addr, core_mem_write_data,
    output core_mem_read_data,
    output mem_clk, mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output start, abort, message_addr, output_addr, nonce_first, nonce_count,
    input  busy, done, aborted, nonces_done,
    input  core_start, core_message_addr, core_output_addr,
    output core_done, core_mem_we, core_mem_addr, core_mem_write_data,
    input  core_mem_read_data,
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/sha256_nonce_sequencer.sv
// Nonce sweep controller for the simplified SHA-256 core. For each nonce it
// patches the nonce word of the message in shared memory, kicks the core,
// waits for the core to finish and steps the digest pointer. It owns the one
// memory port and hands it to the core only while the core is running.
module sha256_nonce_sequencer #(
  parameter int NONCE_OFFSET = 19,
  parameter int OUT_STRIDE   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sha256_nonce_sequencer_if.slave  bus
);

  localparam logic [15:0] LP_NONCE_OFFSET = 16'(NONCE_OFFSET);
  localparam logic [15:0] LP_OUT_STRIDE   = 16'(OUT_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NWR,
    S_KICK,
    S_WLOW,
    S_WHIGH,
    S_NEXT,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_accept;

  logic [15:0] r_msgAddr;
  logic [15:0] r_outPtr;
  logic [31:0] r_nonce;
  logic [15:0] r_remaining;
  logic [15:0] r_noncesDone;
  logic        r_aborted;
  logic        r_abortPending;

  logic        w_memWe;
  logic [15:0] w_memAddr;
  logic [31:0] w_memWriteData;

  // State register; reset drops straight back to IDLE with no done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; start is only taken once the core reports idle, and
  // WLOW swallows the stale done level the core still shows right after KICK.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && bus.core_done) begin
          w_accept    = 1'b1;
          w_nextState = (bus.nonce_count == 16'd0) ? S_FIN : S_NWR;
        end
      end
      S_NWR:   w_nextState = S_KICK;
      S_KICK:  w_nextState = S_WLOW;
      S_WLOW: begin
        if (!bus.core_done) begin
          w_nextState = S_WHIGH;
        end
      end
      S_WHIGH: begin
        if (bus.core_done) begin
          w_nextState = S_NEXT;
        end
      end
      S_NEXT: begin
        if (r_remaining == 16'd1 || r_abortPending) begin
          w_nextState = S_FIN;
        end else begin
          w_nextState = S_NWR;
        end
      end
      S_FIN:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Job registers: loaded on acceptance, stepped once per finished hash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msgAddr    <= 16'd0;
      r_outPtr     <= 16'd0;
      r_nonce      <= 32'd0;
      r_remaining  <= 16'd0;
      r_noncesDone <= 16'd0;
      r_aborted    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_msgAddr    <= bus.message_addr;
            r_outPtr     <= bus.output_addr;
            r_nonce      <= bus.nonce_first;
            r_remaining  <= bus.nonce_count;
            r_noncesDone <= 16'd0;
            r_aborted    <= 1'b0;
          end
        end
        S_NEXT: begin
          r_nonce      <= r_nonce + 32'd1;
          r_outPtr     <= r_outPtr + LP_OUT_STRIDE;
          r_noncesDone <= r_noncesDone + 16'd1;
          r_remaining  <= r_remaining - 16'd1;
          // An abort only counts as such if it actually cut the sweep short.
          if (r_remaining != 16'd1 && r_abortPending) begin
            r_aborted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Abort request latch; remembered until the running hash is finished.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_abortPending <= 1'b0;
    end else if (w_accept) begin
      r_abortPending <= 1'b0;
    end else if (bus.abort && r_state != S_IDLE) begin
      r_abortPending <= 1'b1;
    end
  end

  // Memory port mux keyed on registered state, so ownership never flips on
  // the core's done edge.
  always_comb begin
    w_memWe        = 1'b0;
    w_memAddr      = 16'd0;
    w_memWriteData = 32'd0;
    case (r_state)
      S_NWR: begin
        w_memWe        = 1'b1;
        w_memAddr      = r_msgAddr + LP_NONCE_OFFSET;
        w_memWriteData = r_nonce;
      end
      S_KICK, S_WLOW, S_WHIGH: begin
        w_memWe        = bus.core_mem_we;
        w_memAddr      = bus.core_mem_addr;
        w_memWriteData = bus.core_mem_write_data;
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_clk            = clk;
  assign bus.mem_we             = w_memWe;
  assign bus.mem_addr           = w_memAddr;
  assign bus.mem_write_data     = w_memWriteData;
  assign bus.core_mem_read_data = bus.mem_read_data;

  assign bus.busy               = (r_state != S_IDLE);
  assign bus.done               = (r_state == S_FIN);
  assign bus.aborted            = r_aborted;
  assign bus.nonces_done        = r_noncesDone;
  assign bus.core_start         = (r_state == S_KICK);
  assign bus.core_message_addr  = r_msgAddr;
  assign bus.core_output_addr   = r_outPtr;

endmodule
